mem_bus_arbiter: RTL and testbench

//  Shares the single memory/IO bus between the IF fetch port and the MEM-stage data port.

---
 rtl/mem_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory/IO bus between the IF fetch port and the MEM data port.
// MEM always has priority; each access is a registered req/ack handshake with a timeout.
module mem_bus_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        i_clock,
    input  logic        i_reset,        // active low
    input  logic        i_flush,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_stall,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic        i_mem_sign,
    input  logic [1:0]  i_mem_width,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_stall,
    output logic        o_mem_misalign,
    output logic        o_bus_timeout,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEM_BUS = 2'd1;
    localparam logic [1:0] S_IF_BUS  = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_mem_done;
    logic        r_if_done;
    logic        r_kill;
    logic [1:0]  r_lane;
    logic [1:0]  r_width;
    logic        r_sign;
    logic        r_bus_timeout;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_mem_rdata;
    logic [31:0] r_if_rdata;

    logic        w_mem_access;
    logic        w_misalign;
    logic        w_mem_stall;
    logic        w_if_stall;
    logic        w_start_mem;
    logic        w_start_if;
    logic        w_timeout;
    logic        w_finish;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_lane_data;
    logic [31:0] w_load_data;

    assign w_mem_access = i_mem_rd | i_mem_wr;
    assign w_misalign   = w_mem_access &
                          (((i_mem_width == 2'b01) & i_mem_addr[0]) |
                           (i_mem_width[1] & (i_mem_addr[1:0] != 2'b00)));
    assign w_mem_stall  = w_mem_access & ~r_mem_done & ~w_misalign;
    assign w_if_stall   = (i_if_req & ~r_if_done) | w_mem_stall;

    assign w_start_mem  = (r_state == S_IDLE) & w_mem_stall;
    assign w_start_if   = (r_state == S_IDLE) & ~w_start_mem & i_if_req & ~i_flush & ~r_if_done;
    assign w_timeout    = (r_state != S_IDLE) & ~i_bus_ack & (r_cnt == TIMEOUT - 8'd1);
    assign w_finish     = (r_state != S_IDLE) & (i_bus_ack | w_timeout);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_mem_wdata;
        case (i_mem_width)
            2'b00: begin
                w_be    = 4'b0001 << i_mem_addr[1:0];
                w_wdata = {4{i_mem_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = i_mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_mem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the address captured at issue, so it cannot drift during the handshake.
    assign w_lane_data = i_bus_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_load_data = i_bus_rdata;
        case (r_width)
            2'b00: w_load_data = {{24{r_sign & w_lane_data[7]}}, w_lane_data[7:0]};
            2'b01: w_load_data = {{16{r_sign & w_lane_data[15]}}, w_lane_data[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_mem_done    <= 1'b0;
            r_if_done     <= 1'b0;
            r_kill        <= 1'b0;
            r_lane        <= 2'b00;
            r_width       <= 2'b00;
            r_sign        <= 1'b0;
            r_bus_timeout <= 1'b0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= 32'd0;
            r_bus_be      <= 4'd0;
            r_bus_wdata   <= 32'd0;
            r_mem_rdata   <= 32'd0;
            r_if_rdata    <= 32'd0;
        end else begin
            r_bus_timeout <= 1'b0;
            // A done flag lives exactly until the pipeline has advanced past its stall.
            if (r_mem_done && !w_mem_stall) r_mem_done <= 1'b0;
            if (r_if_done && !w_if_stall)   r_if_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start_mem) begin
                        r_state     <= S_MEM_BUS;
                        r_cnt       <= 8'd0;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= i_mem_wr;
                        r_bus_addr  <= {i_mem_addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_lane      <= i_mem_addr[1:0];
                        r_width     <= i_mem_width;
                        r_sign      <= i_mem_sign;
                    end else if (w_start_if) begin
                        r_state     <= S_IF_BUS;
                        r_cnt       <= 8'd0;
                        r_kill      <= 1'b0;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= {i_if_addr[31:2], 2'b00};
                        r_bus_be    <= 4'b1111;
                    end
                end
                S_MEM_BUS: begin
                    if (w_finish) begin
                        r_state       <= S_IDLE;
                        r_bus_req     <= 1'b0;
                        r_bus_we      <= 1'b0;
                        r_mem_done    <= 1'b1;
                        r_bus_timeout <= w_timeout;
                        r_mem_rdata   <= w_timeout ? 32'd0 : w_load_data;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_IF_BUS: begin
                    if (i_flush) r_kill <= 1'b1;
                    if (w_finish) begin
                        r_state       <= S_IDLE;
                        r_bus_req     <= 1'b0;
                        r_kill        <= 1'b0;
                        r_if_done     <= ~(r_kill | i_flush);
                        r_bus_timeout <= w_timeout;
                        r_if_rdata    <= w_timeout ? 32'd0 : i_bus_rdata;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_if_rdata     = r_if_rdata;
    assign o_if_stall     = w_if_stall;
    assign o_mem_rdata    = r_mem_rdata;
    assign o_mem_stall    = w_mem_stall;
    assign o_mem_misalign = w_misalign;
    assign o_bus_timeout  = r_bus_timeout;
    assign o_bus_req      = r_bus_req;
    assign o_bus_we       = r_bus_we;
    assign o_bus_addr     = r_bus_addr;
    assign o_bus_be       = r_bus_be;
    assign o_bus_wdata    = r_bus_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: loads/stores, lane handling, priority, flush,
// asynchronous reset mid-access and the 255-cycle timeout.
module tb_mem_bus_arbiter;

    logic        i_clock;
    logic        i_reset;
    logic        i_flush;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic [31:0] o_if_rdata;
    logic        o_if_stall;
    logic        i_mem_rd;
    logic        i_mem_wr;
    logic        i_mem_sign;
    logic [1:0]  i_mem_width;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_wdata;
    logic [31:0] o_mem_rdata;
    logic        o_mem_stall;
    logic        o_mem_misalign;
    logic        o_bus_timeout;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic [31:0] i_bus_rdata;
    logic        i_bus_ack;

    int n_checks = 0;
    int n_pass   = 0;

    mem_bus_arbiter #(.TIMEOUT(8'd255)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_flush        (i_flush),
        .i_if_req       (i_if_req),
        .i_if_addr      (i_if_addr),
        .o_if_rdata     (o_if_rdata),
        .o_if_stall     (o_if_stall),
        .i_mem_rd       (i_mem_rd),
        .i_mem_wr       (i_mem_wr),
        .i_mem_sign     (i_mem_sign),
        .i_mem_width    (i_mem_width),
        .i_mem_addr     (i_mem_addr),
        .i_mem_wdata    (i_mem_wdata),
        .o_mem_rdata    (o_mem_rdata),
        .o_mem_stall    (o_mem_stall),
        .o_mem_misalign (o_mem_misalign),
        .o_bus_timeout  (o_bus_timeout),
        .o_bus_req      (o_bus_req),
        .o_bus_we       (o_bus_we),
        .o_bus_addr     (o_bus_addr),
        .o_bus_be       (o_bus_be),
        .o_bus_wdata    (o_bus_wdata),
        .i_bus_rdata    (i_bus_rdata),
        .i_bus_ack      (i_bus_ack)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic set_mem(input logic rd, input logic wr, input logic [1:0] width,
                           input logic sign, input logic [31:0] addr, input logic [31:0] wdata);
        i_mem_rd    = rd;
        i_mem_wr    = wr;
        i_mem_width = width;
        i_mem_sign  = sign;
        i_mem_addr  = addr;
        i_mem_wdata = wdata;
    endtask

    task automatic ack(input logic [31:0] data);
        i_bus_ack   = 1'b1;
        i_bus_rdata = data;
        tick();
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'd0;
    endtask

    // The MEM stage advances once stall is low; the next instruction is not a memory op.
    task automatic retire_mem();
        set_mem(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        tick();
    endtask

    // Single-cycle-ack load returning the extended data, bus_be captured at issue.
    task automatic quick_load(input logic [1:0] width, input logic sign, input logic [31:0] addr,
                              input logic [31:0] rdata, output logic [3:0] be,
                              output logic [31:0] result);
        set_mem(1'b1, 1'b0, width, sign, addr, 32'd0);
        tick();
        be = o_bus_be;
        ack(rdata);
        result = o_mem_rdata;
        retire_mem();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          stall_cnt;
        int          req_cnt;
        logic [3:0]  be;
        logic [31:0] res;

        i_reset = 1'b0; i_flush = 1'b0; i_if_req = 1'b0; i_if_addr = 32'd0;
        i_bus_ack = 1'b0; i_bus_rdata = 32'd0;
        set_mem(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        tick(); tick();
        check("rst_bus_req",  {31'd0, o_bus_req}, 32'd0);
        check("rst_mem_stall", {31'd0, o_mem_stall}, 32'd0);
        check("rst_if_stall", {31'd0, o_if_stall}, 32'd0);
        check("rst_mem_rdata", o_mem_rdata, 32'd0);
        check("rst_timeout",  {31'd0, o_bus_timeout}, 32'd0);
        i_reset = 1'b1;
        tick();

        // lw 0x100, ack on the third bus cycle
        set_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
        #1;
        stall_cnt = o_mem_stall ? 1 : 0;
        tick();
        check("lw_bus_req", {31'd0, o_bus_req}, 32'd1);
        check("lw_be",      {28'd0, o_bus_be}, 32'h0000_000f);
        check("lw_addr",    o_bus_addr, 32'h0000_0100);
        check("lw_we",      {31'd0, o_bus_we}, 32'd0);
        if (o_mem_stall) stall_cnt++;
        tick(); if (o_mem_stall) stall_cnt++;
        tick(); if (o_mem_stall) stall_cnt++;
        ack(32'hDEAD_BEEF);
        if (o_mem_stall) stall_cnt++;
        check("lw_stall_cycles", stall_cnt, 32'd4);
        check("lw_rdata",        o_mem_rdata, 32'hDEAD_BEEF);
        check("lw_req_dropped",  {31'd0, o_bus_req}, 32'd0);
        retire_mem();
        $display("txn lw 0x100 -> %08h", o_mem_rdata);

        quick_load(2'b00, 1'b1, 32'h0000_0103, 32'h8000_0000, be, res);
        check("lb_be",    {28'd0, be}, 32'h0000_0008);
        check("lb_rdata", res, 32'hFFFF_FF80);
        $display("txn lb 0x103 -> %08h", res);
        quick_load(2'b00, 1'b0, 32'h0000_0103, 32'h8000_0000, be, res);
        check("lbu_rdata", res, 32'h0000_0080);
        $display("txn lbu 0x103 -> %08h", res);
        quick_load(2'b01, 1'b1, 32'h0000_0102, 32'h8001_1234, be, res);
        check("lh_be",    {28'd0, be}, 32'h0000_000c);
        check("lh_rdata", res, 32'hFFFF_8001);
        $display("txn lh 0x102 -> %08h", res);
        quick_load(2'b01, 1'b0, 32'h0000_0100, 32'h8001_F234, be, res);
        check("lhu_be",    {28'd0, be}, 32'h0000_0003);
        check("lhu_rdata", res, 32'h0000_F234);
        $display("txn lhu 0x100 -> %08h", res);

        // sh 0x202
        set_mem(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD);
        tick();
        check("sh_we",    {31'd0, o_bus_we}, 32'd1);
        check("sh_be",    {28'd0, o_bus_be}, 32'h0000_000c);
        check("sh_wdata", o_bus_wdata, 32'hABCD_ABCD);
        check("sh_addr",  o_bus_addr, 32'h0000_0200);
        ack(32'd0);
        check("sh_stall_low", {31'd0, o_mem_stall}, 32'd0);
        retire_mem();
        $display("txn sh 0x202 wdata %08h", 32'h1234_ABCD);

        // sb 0x101
        set_mem(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00A5);
        tick();
        check("sb_be",    {28'd0, o_bus_be}, 32'h0000_0002);
        check("sb_wdata", o_bus_wdata, 32'hA5A5_A5A5);
        ack(32'd0);
        retire_mem();
        $display("txn sb 0x101 wdata a5");

        // misaligned half and word: no bus cycle, no stall
        set_mem(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0201, 32'h1234_ABCD);
        #1;
        check("msh_misalign", {31'd0, o_mem_misalign}, 32'd1);
        check("msh_stall",    {31'd0, o_mem_stall}, 32'd0);
        tick(); tick();
        check("msh_no_req",   {31'd0, o_bus_req}, 32'd0);
        set_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'd0);
        #1;
        check("mlw_misalign", {31'd0, o_mem_misalign}, 32'd1);
        tick();
        check("mlw_no_req",   {31'd0, o_bus_req}, 32'd0);
        retire_mem();
        check("aligned_no_misalign", {31'd0, o_mem_misalign}, 32'd0);
        $display("txn misaligned sh 0x201 / lw 0x102 trapped");

        // IF and MEM together: MEM first, IF the cycle after mem_done
        i_if_req = 1'b1; i_if_addr = 32'h0000_0400;
        set_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'd0);
        #1;
        check("pri_if_stall0", {31'd0, o_if_stall}, 32'd1);
        tick();
        check("pri_mem_first", o_bus_addr, 32'h0000_0104);
        check("pri_if_stall1", {31'd0, o_if_stall}, 32'd1);
        ack(32'h1111_1111);
        check("pri_mem_stall", {31'd0, o_mem_stall}, 32'd0);
        check("pri_if_stall2", {31'd0, o_if_stall}, 32'd1);
        check("pri_mem_rdata", o_mem_rdata, 32'h1111_1111);
        set_mem(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        tick();
        check("pri_if_req",  {31'd0, o_bus_req}, 32'd1);
        check("pri_if_addr", o_bus_addr, 32'h0000_0400);
        check("pri_if_stall3", {31'd0, o_if_stall}, 32'd1);
        ack(32'hCAFE_F00D);
        check("pri_if_done",  {31'd0, o_if_stall}, 32'd0);
        check("pri_if_rdata", o_if_rdata, 32'hCAFE_F00D);
        i_if_req = 1'b0;
        tick();
        $display("txn mem 0x104 then fetch 0x400 -> %08h", o_if_rdata);

        // Timeout on a load: 255 cycles of bus_req, then abort
        set_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_010C, 32'd0);
        tick();
        req_cnt = 0;
        while (o_bus_req && req_cnt < 400) begin
            req_cnt++;
            tick();
        end
        check("to_req_cycles", req_cnt, 32'd255);
        check("to_pulse",      {31'd0, o_bus_timeout}, 32'd1);
        check("to_rdata",      o_mem_rdata, 32'd0);
        check("to_stall",      {31'd0, o_mem_stall}, 32'd0);
        retire_mem();
        check("to_pulse_end",  {31'd0, o_bus_timeout}, 32'd0);
        $display("txn lw 0x10c timed out after %0d cycles", req_cnt);

        // Flush during IF_BUS: ack completes, fetch is not accepted, refetch follows
        i_if_req = 1'b1; i_if_addr = 32'h0000_0500;
        tick();
        check("fl_req", {31'd0, o_bus_req}, 32'd1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        ack(32'h5555_5555);
        check("fl_req_drop", {31'd0, o_bus_req}, 32'd0);
        check("fl_if_stall", {31'd0, o_if_stall}, 32'd1);
        tick();
        check("fl_refetch",      {31'd0, o_bus_req}, 32'd1);
        check("fl_refetch_addr", o_bus_addr, 32'h0000_0500);
        ack(32'h6666_6666);
        check("fl_done",  {31'd0, o_if_stall}, 32'd0);
        check("fl_rdata", o_if_rdata, 32'h6666_6666);
        i_if_req = 1'b0;
        tick();
        $display("txn flushed fetch 0x500 refetched -> %08h", o_if_rdata);

        // Reset mid MEM_BUS: bus_req drops without waiting for a clock edge
        set_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0108, 32'd0);
        tick();
        check("rs_req_before", {31'd0, o_bus_req}, 32'd1);
        i_reset = 1'b0;
        #1;
        check("rs_req_async", {31'd0, o_bus_req}, 32'd0);
        check("rs_still_stalled", {31'd0, o_mem_stall}, 32'd1);
        set_mem(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        tick();
        i_reset = 1'b1;
        tick();
        check("rs_idle", {31'd0, o_bus_req}, 32'd0);
        $display("txn reset during lw 0x108");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
